// File: rtl/clk_div_pkg.sv
// Shared types for the divided-clock monitor, the divider and the
// host-register block.
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_edge_det.sv
// div_in sampler and edge strobes; CLK_DIV_MON_SYNC_EN adds a
// two-flop synchronizer ahead of s_cur for asynchronous sources.
module clk_div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic s_cur,
  output logic rise,
  output logic fall
);

  logic din;
  logic s_cur_q;
  logic s_prev_q;

`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], div_in};
  end

  assign din = sync_q[1];
`else
  assign din = div_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cur_q  <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_cur_q  <= din;
      s_prev_q <= s_cur_q;
    end
  end

  assign s_cur = s_cur_q;
  assign rise  = s_cur_q & ~s_prev_q;
  assign fall  = ~s_cur_q & s_prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures high/low phases of a divided clock and flags mismatch/stuck.
// Define CLK_DIV_MON_SYNC_EN to synchronize div_in (2 extra cycles).
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int          CNT_W   = CNT_W_DEF,
  parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  input  logic             clr_err,
  output logic [CNT_W-1:0] hi_meas,
  output logic [CNT_W-1:0] lo_meas,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_cnt,
  output logic             mismatch,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + ONE;
  endfunction

  logic s_cur, rise, fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] hi_meas_q, hi_meas_d;
  logic [CNT_W-1:0] lo_meas_q, lo_meas_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             mv_q, mv_d;
  logic             mm_q, mm_d;
  logic             stuck_q, stuck_d;
  logic [31:0]      to_q, to_d;
  logic             new_mm;

  clk_div_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .s_cur  (s_cur),
    .rise   (rise),
    .fall   (fall)
  );

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    hi_meas_d = hi_meas_q;
    lo_meas_d = lo_meas_q;
    pcnt_d    = pcnt_q;
    mv_d      = 1'b0;
    mm_d      = mm_q;
    stuck_d   = stuck_q;
    to_d      = to_q;
    new_mm    = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      pcnt_d   = '0;
      stuck_d  = 1'b0;
      to_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            hi_cnt_d = ONE;
            state_d  = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_meas_d = hi_cnt_q;
            lo_cnt_d  = ONE;
            state_d   = LOW;
          end else if (s_cur) begin
            hi_cnt_d = sat_inc(hi_cnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            lo_meas_d = lo_cnt_q;
            mv_d      = 1'b1;
            pcnt_d    = sat_inc(pcnt_q);
            new_mm    = (hi_meas_q != exp_high) ||
                        (lo_cnt_q != exp_low);
            hi_cnt_d  = ONE;
            state_d   = HIGH;
          end else if (!s_cur) begin
            lo_cnt_d = sat_inc(lo_cnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
      // a fresh mismatch wins over a same-cycle clear
      mm_d = (mm_q & ~clr_err) | new_mm;
      if (rise || fall) begin
        to_d    = '0;
        stuck_d = 1'b0;
      end else begin
        to_d    = (to_q < TIMEOUT) ? to_q + 32'd1 : to_q;
        stuck_d = (to_d >= TIMEOUT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      hi_meas_q <= '0;
      lo_meas_q <= '0;
      pcnt_q    <= '0;
      mv_q      <= 1'b0;
      mm_q      <= 1'b0;
      stuck_q   <= 1'b0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      hi_meas_q <= hi_meas_d;
      lo_meas_q <= lo_meas_d;
      pcnt_q    <= pcnt_d;
      mv_q      <= mv_d;
      mm_q      <= mm_d;
      stuck_q   <= stuck_d;
      to_q      <= to_d;
    end
  end

  assign hi_meas    = hi_meas_q;
  assign lo_meas    = lo_meas_q;
  assign meas_valid = mv_q;
  assign period_cnt = pcnt_q;
  assign mismatch   = mm_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Random and directed stimulus for clk_div_monitor, checked against a
// run-length reference model of the sampled div_in waveform.
module tb_clk_div_monitor;

  localparam int CW   = 4;
  localparam int TO   = 16;
  localparam int MAXV = 15;
`ifdef CLK_DIV_MON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          div_in = 1'b0;
  logic          clr_err = 1'b0;
  logic [CW-1:0] exp_high = '0;
  logic [CW-1:0] exp_low = '0;
  logic [CW-1:0] hi_meas, lo_meas, period_cnt;
  logic          meas_valid, mismatch, stuck;

  clk_div_monitor #(
    .CNT_W   (CW),
    .TIMEOUT (32'd16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .exp_high   (exp_high),
    .exp_low    (exp_low),
    .clr_err    (clr_err),
    .hi_meas    (hi_meas),
    .lo_meas    (lo_meas),
    .meas_valid (meas_valid),
    .period_cnt (period_cnt),
    .mismatch   (mismatch),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  bit g_en;
  int g_eh, g_el;
  bit g_lvl;
  bit pq[$];

  int m_prev, m_run, m_armed, m_hh;
  int m_hi, m_lo, m_mv, m_pc, m_mm, m_stuck;
  int m_last, m_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic m_reset();
    m_prev = 0; m_run = 0; m_armed = 0; m_hh = 0;
    m_hi = 0; m_lo = 0; m_mv = 0; m_pc = 0; m_mm = 0; m_stuck = 0;
    m_last = m_cyc;
  endtask

  // One clk edge as seen by the monitor: v is the sample reaching it.
  task automatic m_step();
    int v, r, f, nm;
    m_cyc++;
    if (rst) begin
      m_reset();
      return;
    end
    v = int'(pq.pop_front());
    r = (v == 1 && m_prev == 0) ? 1 : 0;
    f = (v == 0 && m_prev == 1) ? 1 : 0;
    m_prev = v;
    m_mv = 0;
    nm = 0;
    if (!en) begin
      m_armed = 0; m_hh = 0; m_pc = 0; m_stuck = 0;
      m_last = m_cyc;
      return;
    end
    if (r == 1) begin
      if (m_armed == 1 && m_hh == 1) begin
        m_lo = sat(m_run);
        m_mv = 1;
        m_pc = sat(m_pc + 1);
        nm = (m_hi != g_eh || m_lo != g_el) ? 1 : 0;
      end
      m_armed = 1; m_hh = 0; m_run = 1;
    end else if (f == 1) begin
      if (m_armed == 1) begin
        m_hi = sat(m_run);
        m_hh = 1;
      end
      m_run = 1;
    end else begin
      m_run++;
    end
    m_mm = ((m_mm == 1 && !clr_err) || nm == 1) ? 1 : 0;
    if (r == 1 || f == 1) m_last = m_cyc;
    m_stuck = (m_cyc - m_last >= TO) ? 1 : 0;
  endtask

  task automatic tick(input bit d, input bit c);
    div_in   = d;
    clr_err  = c;
    en       = g_en;
    exp_high = CW'(g_eh);
    exp_low  = CW'(g_el);
    g_lvl    = d;
    if (rst) begin
      pq.delete();
      repeat (LAT) pq.push_back(1'b0);
    end else begin
      pq.push_back(d);
    end
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("hi_meas", 32'(hi_meas), m_hi);
    chk("lo_meas", 32'(lo_meas), m_lo);
    chk("meas_valid", 32'(meas_valid), m_mv);
    chk("period_cnt", 32'(period_cnt), m_pc);
    chk("mismatch", 32'(mismatch), m_mm);
    chk("stuck", 32'(stuck), m_stuck);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_hi", 32'(hi_meas), 0);
    chk("rst_lo", 32'(lo_meas), 0);
    chk("rst_mv", 32'(meas_valid), 0);
    chk("rst_pc", 32'(period_cnt), 0);
    chk("rst_mm", 32'(mismatch), 0);
    chk("rst_stuck", 32'(stuck), 0);
    pq.delete();
    repeat (LAT) pq.push_back(1'b0);
    repeat (n) tick(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) tick(1'b1, 1'b0);
      repeat (l) tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    m_cyc = 0;
    g_en = 1'b0; g_eh = 0; g_el = 0; g_lvl = 1'b0;
    #2;
    do_reset(3);

    // 3/5 waveform, matching expectations
    g_en = 1'b1; g_eh = 3; g_el = 5;
    wave(3, 5, 6);
    chk("hi_35", 32'(hi_meas), 3);
    chk("lo_35", 32'(lo_meas), 5);
    chk("mm_35", 32'(mismatch), 0);
    chk("pc_35", 32'(period_cnt), 5);

    // wrong expected high, clear, reassert
    g_eh = 4;
    wave(3, 5, 2);
    chk("mm_set", 32'(mismatch), 1);
    tick(1'b0, 1'b1);
    chk("mm_clr", 32'(mismatch), 0);
    wave(3, 5, 1);
    chk("mm_again", 32'(mismatch), 1);
    tick(1'b1, 1'b0);
    repeat (LAT - 1) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("mm_clr_same", 32'(mismatch), 1);
    repeat (5) tick(1'b0, 1'b0);

    // stuck high, then a fall clears it; high time saturates
    g_eh = 3;
    repeat (25) tick(1'b1, 1'b0);
    chk("stuck_set", 32'(stuck), 1);
    repeat (LAT + 1) tick(1'b0, 1'b0);
    chk("stuck_clr", 32'(stuck), 0);
    chk("hi_sat", 32'(hi_meas), 15);

    // reset in the middle of a low phase
    wave(3, 5, 2);
    repeat (3) tick(1'b1, 1'b0);
    repeat (LAT + 2) tick(1'b0, 1'b0);
    do_reset(2);
    wave(3, 5, 2);
    chk("pc_after_rst", 32'(period_cnt), 1);

    // enable drop with a 1/1 waveform
    g_eh = 1; g_el = 1;
    wave(1, 1, 6);
    g_en = 1'b0;
    wave(1, 1, 3);
    chk("pc_dis", 32'(period_cnt), 0);
    chk("stuck_dis", 32'(stuck), 0);
    chk("hi_dis", 32'(hi_meas), 1);
    g_en = 1'b1;
    wave(1, 1, 6);
    chk("hi_11", 32'(hi_meas), 1);
    chk("lo_11", 32'(lo_meas), 1);

    // randomized waveforms, enables, clears, resets and stalls
    for (int i = 0; i < 150; i++) begin
      int h, l, n, r;
      h = int'($urandom_range(1, 18));
      l = int'($urandom_range(1, 18));
      n = int'($urandom_range(1, 4));
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else if (r == 1) begin
        g_en = 1'b0;
        repeat ($urandom_range(1, 5))
          tick(1'($urandom_range(0, 1)), 1'b0);
        g_en = 1'b1;
      end else if (r == 2) begin
        tick(g_lvl, 1'b1);
      end else if (r == 3) begin
        repeat ($urandom_range(17, 28)) tick(g_lvl, 1'b0);
      end
      g_eh = ($urandom_range(0, 1) == 1) ? sat(h)
                                          : int'($urandom_range(0, 15));
      g_el = ($urandom_range(0, 1) == 1) ? sat(l)
                                          : int'($urandom_range(0, 15));
      wave(h, l, n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of all count ports and internal counters.
REQ-002 SHALL have parameter TIMEOUT, default 32'd100_000_000: clk cycles without a div_in edge before stuck asserts.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1: monitor enable; 0 forces IDLE.
REQ-006 SHALL have port div_in, input, 1: divided-clock output under test, sampled as data.
REQ-007 SHALL have port exp_high, input, CNT_W: expected high time in clk cycles.
REQ-008 SHALL have port exp_low, input, CNT_W: expected low time in clk cycles.
REQ-009 SHALL have port clr_err, input, 1: single-cycle clear of the sticky mismatch flag.
REQ-010 SHALL have port hi_meas, output, CNT_W: last completed high duration.
REQ-011 SHALL have port lo_meas, output, CNT_W: last completed low duration.
REQ-012 SHALL have port meas_valid, output, 1: one-cycle pulse when a full high+low period completes.
REQ-013 SHALL have port period_cnt, output, CNT_W: completed periods since reset or enable.
REQ-014 SHALL have port mismatch, output, 1: sticky; a completed period differed from exp_high/exp_low.
REQ-015 SHALL have port stuck, output, 1: no div_in edge seen for TIMEOUT cycles.

Function
REQ-016 SHALL sample div_in into s_cur and keep the previous sample s_prev; rise = s_cur & ~s_prev, fall = ~s_cur & s_prev.
REQ-017 SHALL implement states IDLE, HIGH, LOW; from IDLE, the first rise enters HIGH, and a partial first high phase is never measured.
REQ-018 In HIGH, SHALL load hi_cnt=1 on entry and increment it each cycle s_cur=1; on fall SHALL latch hi_meas=hi_cnt, load lo_cnt=1 and enter LOW.
REQ-019 In LOW, SHALL increment lo_cnt each cycle s_cur=0; on rise SHALL latch lo_meas=lo_cnt, pulse meas_valid the next cycle, increment period_cnt, load hi_cnt=1 and enter HIGH.
REQ-020 SHALL assert mismatch in the meas_valid cycle if hi_meas!=exp_high or lo_meas!=exp_low, using exp values sampled on that rise.
REQ-021 If clr_err and a new mismatch occur in the same cycle, mismatch SHALL remain 1.
REQ-022 hi_cnt, lo_cnt and period_cnt SHALL saturate at all-ones and never wrap.
REQ-023 SHALL assert stuck when the cycle count since the last edge reaches TIMEOUT, in any state with en=1; SHALL deassert it on the cycle after the next edge.
REQ-024 en=0 SHALL force IDLE, clear hi_cnt, lo_cnt, period_cnt and stuck, and hold hi_meas, lo_meas and mismatch; re-enable SHALL resume at REQ-017.
REQ-025 Latency from a div_in edge to the internal edge strobe SHALL be 1 clk cycle without SYNC, or 3 cycles with CLK_DIV_MON_SYNC_EN.

Reset
REQ-026 On rst=1 all outputs SHALL be 0, the state SHALL be IDLE, and the sample/synchronizer flops SHALL be 0, independent of clk.
REQ-027 Reset asserted mid-period SHALL discard partial counts; the first measurement after release SHALL follow REQ-017.

Configuration
REQ-028 With CLK_DIV_MON_SYNC_EN defined, a two-flop synchronizer SHALL precede s_cur, for div_in from an external pin or another domain.
REQ-029 Without CLK_DIV_MON_SYNC_EN, div_in SHALL be registered once; the measured values are identical, only the latency differs.

Structure
REQ-030 A shared package clk_div_pkg SHALL hold the state enum (IDLE/HIGH/LOW) and the CNT_W default constant, for reuse by the divider and host-register logic.
REQ-031 The edge detector and optional synchronizer SHALL be one sub-module, clk_div_edge_det (outputs rise, fall, s_cur); all other logic stays in clk_div_monitor.

Verification
REQ-032 div_in high 3 / low 5, exp 3/5, en=1 -> from the 2nd rise, meas_valid every 8 cycles; hi_meas=3, lo_meas=5, mismatch=0, period_cnt increments by 1 per pulse.
REQ-033 Same waveform with exp_high=4 -> mismatch=1 at the first meas_valid; clr_err pulse -> 0; mismatch reasserts at the next meas_valid.
REQ-034 div_in held at 1, TIMEOUT=16 -> stuck=1 16 cycles after the last edge; a fall then clears stuck; hi_meas saturates only if CNT_W is small (run with CNT_W=4: 15).
REQ-035 rst pulse mid-LOW after 2 periods -> all outputs 0 immediately; the next meas_valid only after a full rise-fall-rise sequence.
REQ-036 en 1->0->1 with a 1/1 waveform -> period_cnt=0 and stuck=0 while disabled, hi_meas held; after re-enable hi_meas=1, lo_meas=1; rerun with CLK_DIV_MON_SYNC_EN -> same values, meas_valid 2 cycles later.
